miller_rx_ctrl: RTL
===================

# miller_rx_ctrl

Receive-window controller for the Miller-subcarrier tag-reply decoder in the reader back end. It arms the decoder with the configured M value and gates its enable. It also enforces the T1 reply timeout and re-times the decoder's bit strobes into the dec_clk domain as a bit stream. Each reply window closes with a status code: OK, timeout, length error or abort.

## Interface
Parameters:
- QUIET, 4, number of cycles miller_en is held low in FINISH before returning to IDLE (≥1)
- TMO_W, 16, width of T1 timeout counter

Ports:
- dec_clk  in  1  controller clock; same source as the decoder base clock
- rst_n  in  1  reset; asynchronous, active-low
- rx_req  in  1  one-cycle request to open a receive window; honoured only in IDLE
- rx_abort  in  1  level/pulse; forces window closure
- cfg_m  in  2  Miller M select: 01=M2, 10=M4, other=M8
- cfg_len  in  8  expected reply bits; 0 = unbounded (end on decoder done)
- cfg_t1  in  TMO_W  T1 timeout in dec_clk cycles; 0 = no timeout
- miller_en  out  1  decoder enable
- m_value  out  2  latched M select to decoder
- dec_start  in  1  decoder preamble-detected strobe
- dec_bclk  in  1  decoder recovered bit strobe (miller_clk)
- dec_data  in  1  decoder bit value (miller_data)
- dec_done  in  1  decoder end-of-reply strobe
- bit_data  out  1  received bit, valid with bit_valid
- bit_valid  out  1  one-cycle bit strobe
- bit_cnt  out  8  bits delivered in current window, saturating at 255
- rx_busy  out  1  high in any state but IDLE
- rx_done  out  1  one-cycle end-of-window pulse
- rx_status  out  2  00 OK, 01 timeout, 10 length error, 11 abort; valid from rx_done until next accepted rx_req

## Operation
- Reset values: miller_en=0, m_value=00, bit_data=0, bit_valid=0, bit_cnt=0, rx_busy=0, rx_done=0, rx_status=00, state IDLE, all counters 0.

Input conditioning:
- dec_start, dec_bclk, dec_done, dec_data each pass through a 2-flop synchronizer.
- Events are rising edges detected at stage 3.
- dec_data is synchronized in lockstep with dec_bclk and sampled at the same stage.

States:
- IDLE: on rx_req && !rx_abort, latch cfg_m into m_value, plus cfg_len and cfg_t1. Clear bit_cnt and rx_status, then go to ARM.
- ARM (1 cycle): miller_en=1, clear timeout counter, go to WAIT_PRE.
- WAIT_PRE: miller_en=1 and the timeout counter increments each cycle.
  - Start edge → RECV.
  - Counter == cfg_t1 with cfg_t1≠0 → FINISH, status 01.
  - If the start edge and timeout occur in the same cycle, start wins.
- RECV: miller_en=1.
  - Each dec_bclk edge: bit_valid=1, bit_data=synced data, bit_cnt+1.
  - If cfg_len≠0 and the increment reaches cfg_len → FINISH, status 00.
  - If cfg_len=0 and bit_cnt reaches 255 → FINISH, status 10.
  - Done edge → FINISH. Status is 00 if cfg_len=0, else 10 (short reply).
  - A bit edge and done edge in the same cycle: the bit is delivered first and counted, then the rules above are evaluated with the new count.
- FINISH: miller_en=0 for QUIET cycles. Bit, start and done edges are ignored. Then go to IDLE with rx_done=1 for 1 cycle.

Precedence and special cases:
- rx_abort in ARM, WAIT_PRE or RECV → FINISH with status 11. Abort overrides every same-cycle completion.
- rx_abort in FINISH has no effect.
- rx_req outside IDLE is ignored.
- A start edge arriving in RECV is ignored.
- Timeout counter saturates at all-ones.

## Timing
- rx_req sampled in cycle n: ARM in n+1, miller_en high from n+1. Timeout counting starts in n+2.
- Decoder strobe rising at cycle k: internal event at k+3. bit_valid is registered, so it is high at k+4.
- Completion decided in cycle c: FINISH from c+1 and miller_en low from c+1. rx_done is high at c+1+QUIET, with rx_busy low in the same cycle.
- rx_status updates on the cycle FINISH is entered.
- Back-to-back: rx_req is accepted in the same cycle rx_done is high (first IDLE cycle).
- Async reset mid-window: all outputs return to reset values immediately. No rx_done is issued.

## Test plan
- M4, cfg_len=16, cfg_t1=1000; start at +200 cycles, 16 bit strobes alternating 1/0 → 16 bit_valid pulses, data 1010…, bit_cnt=16, rx_status=00, rx_done once.
- cfg_t1=50, no dec_start → miller_en drops 52 cycles after rx_req, rx_status=01, rx_done after QUIET cycles.
- cfg_len=32, only 20 bits then dec_done → bit_cnt=20, rx_status=10.
- cfg_len=0, 40 bits then dec_done → bit_cnt=40, rx_status=00.
- rx_abort during RECV in the same cycle as the final expected bit → bit delivered, rx_status=11.
- rx_req during RECV, then rx_req again in the rx_done cycle → first ignored, second opens a new window with bit_cnt=0.
- rst_n pulsed mid-RECV → all outputs at reset values, no rx_done.

Source files
------------

// File: rtl/miller_rx_ctrl_if.sv
// Host/decoder-facing signal bundle of the Miller receive-window controller.
interface miller_rx_ctrl_if #(
    parameter int unsigned TMO_W = 16
);

    logic             rx_req;
    logic             rx_abort;
    logic [1:0]       cfg_m;
    logic [7:0]       cfg_len;
    logic [TMO_W-1:0] cfg_t1;
    logic             miller_en;
    logic [1:0]       m_value;
    logic             dec_start;
    logic             dec_bclk;
    logic             dec_data;
    logic             dec_done;
    logic             bit_data;
    logic             bit_valid;
    logic [7:0]       bit_cnt;
    logic             rx_busy;
    logic             rx_done;
    logic [1:0]       rx_status;

    // Host plus decoder side: issues requests/config and the raw decoder strobes.
    modport master (
        output rx_req, rx_abort, cfg_m, cfg_len, cfg_t1,
               dec_start, dec_bclk, dec_data, dec_done,
        input  miller_en, m_value, bit_data, bit_valid, bit_cnt,
               rx_busy, rx_done, rx_status
    );

    // Controller side.
    modport slave (
        input  rx_req, rx_abort, cfg_m, cfg_len, cfg_t1,
               dec_start, dec_bclk, dec_data, dec_done,
        output miller_en, m_value, bit_data, bit_valid, bit_cnt,
               rx_busy, rx_done, rx_status
    );

endinterface

// File: rtl/miller_rx_ctrl.sv
// Receive-window controller for the Miller subcarrier decoder: arms the decoder,
// enforces the T1 reply timeout, re-times bit strobes and reports window status.
module miller_rx_ctrl #(
    parameter int unsigned QUIET = 4,
    parameter int unsigned TMO_W = 16
) (
    input  logic            dec_clk,
    input  logic            rst_n,
    miller_rx_ctrl_if.slave bus
);

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned SYNC_N = 4;
    localparam int unsigned QC_W   = (QUIET > 1) ? $clog2(QUIET) : 1;
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(QUIET - 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_TMO   = 2'b01;
    localparam logic [1:0] ST_LEN   = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_PRE,
        S_RECV,
        S_FINISH
    } state_t;

    state_t              state;
    logic [SYNC_N-1:0]   start_sr;
    logic [SYNC_N-1:0]   bclk_sr;
    logic [SYNC_N-1:0]   done_sr;
    logic [SYNC_N-2:0]   data_sr;
    logic [LEN_W-1:0]    len_q;
    logic [TMO_W-1:0]    t1_q;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [QC_W-1:0]     quiet_cnt;

    logic                start_ev_c;
    logic                bclk_ev_c;
    logic                done_ev_c;
    logic [TMO_W-1:0]    tmo_inc_c;
    logic [LEN_W-1:0]    cnt_new_c;
    logic                fin_c;
    logic [1:0]          fin_status_c;

    // Decoder strobes cross into dec_clk: two synchronizer flops, then edge-detect stages.
    always_ff @(posedge dec_clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sr <= '0;
            bclk_sr  <= '0;
            done_sr  <= '0;
            data_sr  <= '0;
        end else begin
            start_sr <= {start_sr[SYNC_N-2:0], bus.dec_start};
            bclk_sr  <= {bclk_sr[SYNC_N-2:0], bus.dec_bclk};
            done_sr  <= {done_sr[SYNC_N-2:0], bus.dec_done};
            data_sr  <= {data_sr[SYNC_N-3:0], bus.dec_data};
        end
    end

    // Rising edges seen at stage 3; data is taken from the same stage as the bit strobe.
    assign start_ev_c = start_sr[2] & ~start_sr[3];
    assign bclk_ev_c  = bclk_sr[2] & ~bclk_sr[3];
    assign done_ev_c  = done_sr[2] & ~done_sr[3];

    // Saturating next values for the timeout counter and the bit counter.
    always_comb begin
        tmo_inc_c = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + TMO_W'(1);
        cnt_new_c = bus.bit_cnt;
        if (bclk_ev_c && (bus.bit_cnt != '1)) begin
            cnt_new_c = bus.bit_cnt + LEN_W'(1);
        end
    end

    // Window-closing decision; abort first, a same-cycle bit is already counted in cnt_new_c.
    always_comb begin
        fin_c        = 1'b0;
        fin_status_c = ST_OK;
        case (state)
            S_ARM: begin
                if (bus.rx_abort) begin
                    fin_c        = 1'b1;
                    fin_status_c = ST_ABORT;
                end
            end
            S_WAIT_PRE: begin
                if (bus.rx_abort) begin
                    fin_c        = 1'b1;
                    fin_status_c = ST_ABORT;
                end else if (!start_ev_c && (t1_q != '0) && (tmo_inc_c == t1_q)) begin
                    fin_c        = 1'b1;
                    fin_status_c = ST_TMO;
                end
            end
            S_RECV: begin
                if (bus.rx_abort) begin
                    fin_c        = 1'b1;
                    fin_status_c = ST_ABORT;
                end else if ((len_q != '0) && bclk_ev_c && (cnt_new_c == len_q)) begin
                    fin_c        = 1'b1;
                    fin_status_c = ST_OK;
                end else if ((len_q == '0) && bclk_ev_c && (cnt_new_c == '1)) begin
                    fin_c        = 1'b1;
                    fin_status_c = ST_LEN;
                end else if (done_ev_c) begin
                    fin_c        = 1'b1;
                    fin_status_c = (len_q == '0) ? ST_OK : ST_LEN;
                end
            end
            default: begin
                fin_c        = 1'b0;
                fin_status_c = ST_OK;
            end
        endcase
    end

    // Window sequencing, decoder enable, bit delivery and status reporting.
    always_ff @(posedge dec_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            len_q         <= '0;
            t1_q          <= '0;
            tmo_cnt       <= '0;
            quiet_cnt     <= '0;
            bus.miller_en <= 1'b0;
            bus.m_value   <= 2'b00;
            bus.bit_data  <= 1'b0;
            bus.bit_valid <= 1'b0;
            bus.bit_cnt   <= '0;
            bus.rx_busy   <= 1'b0;
            bus.rx_done   <= 1'b0;
            bus.rx_status <= ST_OK;
        end else begin
            bus.bit_valid <= 1'b0;
            bus.rx_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.rx_req && !bus.rx_abort) begin
                        bus.m_value   <= bus.cfg_m;
                        len_q         <= bus.cfg_len;
                        t1_q          <= bus.cfg_t1;
                        bus.bit_cnt   <= '0;
                        bus.rx_status <= ST_OK;
                        bus.rx_busy   <= 1'b1;
                        bus.miller_en <= 1'b1;
                        state         <= S_ARM;
                    end
                end
                S_ARM: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_PRE;
                end
                S_WAIT_PRE: begin
                    tmo_cnt <= tmo_inc_c;
                    if (start_ev_c) begin
                        state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (bclk_ev_c) begin
                        bus.bit_valid <= 1'b1;
                        bus.bit_data  <= data_sr[2];
                        bus.bit_cnt   <= cnt_new_c;
                    end
                end
                S_FINISH: begin
                    if (quiet_cnt == QC_LAST) begin
                        bus.rx_busy <= 1'b0;
                        bus.rx_done <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        quiet_cnt <= quiet_cnt + QC_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (fin_c) begin
                bus.miller_en <= 1'b0;
                bus.rx_status <= fin_status_c;
                quiet_cnt     <= '0;
                state         <= S_FINISH;
            end
        end
    end

endmodule
